cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run controller for a small processor core. It holds the core in reset for
//   a fixed number of cycles after system reset, then gates the core's clock
//   enable according to the selected mode: halt, free-run, single-step on a
//   key press, or a fixed-length burst on a key press. It also counts the
//   enabled cycles.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   mode[1:0]    00 halt, 01 free-run, 10 single-step, 11 burst
//   step_req     debounced key level; only its 0->1 transition is used
//   burst_len    enabled cycles per burst, sampled when a burst starts
//   halt_req     level; stops any activity
//   cnt_clr      synchronous clear of cycle_count
//   cpu_reset    active-high reset to the processor
//   cpu_en       processor clock enable
//   busy         high while running, stepping or bursting
//   done         one-cycle pulse after a step or burst completes normally
//   cycle_count  number of cycles with cpu_en=1, saturating
//
// States
//   state        | meaning
//   ST_RST_HOLD  | processor held in reset after system reset release
//   ST_IDLE      | processor stopped, waiting for a run decision
//   ST_RUN       | free-running while mode=01 and no halt
//   ST_STEP      | single enabled cycle
//   ST_BURST     | burst_len enabled cycles, counted by remaining

module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int BURST_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               step_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  input  logic               cnt_clr,
  output logic               cpu_reset,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_BURST
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_next;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] remaining_next;
  logic               done_next;
  logic               step_prev;
  logic               step_edge;

  // The history register is cleared by reset and then follows the input in
  // every state, so a key held through reset release is already "seen" by
  // the time the controller reaches IDLE and never looks like a press.
  assign step_edge = step_req & ~step_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RST_HOLD;
      hold_cnt  <= '0;
      remaining <= '0;
      done      <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      remaining <= remaining_next;
      done      <= done_next;
      step_prev <= step_req;
    end
  end

  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    remaining_next = remaining;
    done_next      = 1'b0;

    case (state)
      ST_RST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end

      ST_IDLE: begin
        // halt_req wins over every start condition; presses that do not
        // start anything are simply dropped.
        if (!halt_req) begin
          if (mode == MODE_RUN) begin
            state_next = ST_RUN;
          end else if (mode == MODE_STEP && step_edge) begin
            state_next = ST_STEP;
          end else if (mode == MODE_BURST && step_edge && burst_len != '0) begin
            state_next     = ST_BURST;
            remaining_next = burst_len;
          end
        end
      end

      ST_RUN: begin
        if (mode != MODE_RUN || halt_req) begin
          state_next = ST_IDLE;
        end
      end

      ST_STEP: begin
        // The single enabled cycle has happened either way; a halt only
        // suppresses the completion pulse.
        state_next = ST_IDLE;
        done_next  = ~halt_req;
      end

      ST_BURST: begin
        if (halt_req) begin
          state_next     = ST_IDLE;
          remaining_next = '0;
        end else if (remaining == BURST_W'(1)) begin
          state_next     = ST_IDLE;
          remaining_next = '0;
          done_next      = 1'b1;
        end else begin
          remaining_next = remaining - BURST_W'(1);
        end
      end

      default: begin
        state_next = ST_RST_HOLD;
      end
    endcase
  end

  assign cpu_reset = (state == ST_RST_HOLD);
  assign busy      = (state == ST_RUN) || (state == ST_STEP) || (state == ST_BURST);
  assign cpu_en    = busy;

  // Clear beats increment; the counter sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (cnt_clr) begin
      cycle_count <= '0;
    end else if (cpu_en && cycle_count != CNT_MAX) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
